// File: rtl/text_pixel_pipe.sv
// text_pixel_pipe: drives the font ROM, picks the pixel bit for the current
// column, maps the colour index to 12-bit RGB, blanks outside the visible area
// and re-aligns hsync/vsync with the registered RGB output.
// Optional feature: define TEXT_PIXEL_PIPE_BLINK_EN to blink colour index 15
// using a frame counter clocked by falling edges of vsync_in.

module text_pixel_pipe #(
    parameter int          PIX_DLY   = 1,
    parameter logic [11:0] BG_RGB    = 12'h000,
    parameter int          BLINK_BIT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixelx,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [10:0] rom_addr,
    input  logic [1:0]  font_size,
    input  logic [3:0]  color_addr,
    input  logic        dp,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    // Alignment delay line: bring pixel-timed signals up to the upstream outputs (T0)
    logic [3:0]         px_dly [PIX_DLY];
    logic [PIX_DLY-1:0] von_dly;
    logic [PIX_DLY-1:0] hs_dly;
    logic [PIX_DLY-1:0] vs_dly;

    logic [3:0] px_t0;
    logic       von_t0;
    logic       hs_t0;
    logic       vs_t0;

    // Shift pixel-timed signals; syncs clear to the inactive (high) level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIX_DLY; i++) begin
                px_dly[i] <= 4'd0;
            end
            von_dly <= '0;
            hs_dly  <= '1;
            vs_dly  <= '1;
        end else begin
            px_dly[0]  <= pixelx[3:0];
            von_dly[0] <= video_on;
            hs_dly[0]  <= hsync_in;
            vs_dly[0]  <= vsync_in;
            for (int i = 1; i < PIX_DLY; i++) begin
                px_dly[i]  <= px_dly[i-1];
                von_dly[i] <= von_dly[i-1];
                hs_dly[i]  <= hs_dly[i-1];
                vs_dly[i]  <= vs_dly[i-1];
            end
        end
    end

    assign px_t0  = px_dly[PIX_DLY-1];
    assign von_t0 = von_dly[PIX_DLY-1];
    assign hs_t0  = hs_dly[PIX_DLY-1];
    assign vs_t0  = vs_dly[PIX_DLY-1];

    // The ROM is synchronous, so the row for this address arrives next cycle
    assign font_addr = rom_addr;

    // Stage 1: column select and capture of per-pixel attributes
    logic [2:0] col_d;
    logic [2:0] col_q;
    logic [3:0] color_q;
    logic       dp_q;
    logic       von_q;
    logic       hs_q;
    logic       vs_q;

    // Column within the glyph row; 2x width uses every pixel twice
    always_comb begin
        col_d = px_t0[2:0];
        if (font_size == 2'd2) begin
            col_d = px_t0[3:1];
        end
    end

    // Register stage-1 attributes alongside the ROM read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q   <= 3'd0;
            color_q <= 4'd0;
            dp_q    <= 1'b0;
            von_q   <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            col_q   <= col_d;
            color_q <= color_addr;
            dp_q    <= dp;
            von_q   <= von_t0;
            hs_q    <= hs_t0;
            vs_q    <= vs_t0;
        end
    end

    // Stage 2: bit select, palette lookup and output priority
    logic        font_bit;
    logic [11:0] fg;
    logic        blink_off;
    logic [11:0] rgb_d;
    logic        unused_px;

    assign font_bit  = font_data[3'd7 - col_q];
    assign unused_px = ^pixelx[9:4];

`ifdef TEXT_PIXEL_PIPE_BLINK_EN
    logic [7:0] frame_cnt_q;
    logic       vs_prev_q;

    // Count frames on each falling edge of the raw vsync input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
            vs_prev_q   <= 1'b1;
        end else begin
            vs_prev_q <= vsync_in;
            if (vs_prev_q && !vsync_in) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign blink_off = (color_q == 4'd15) && frame_cnt_q[BLINK_BIT];
`else
    logic unused_blink_bit;

    assign blink_off        = 1'b0;
    assign unused_blink_bit = (BLINK_BIT != 0);
`endif

    // Fixed 16-entry palette
    always_comb begin
        fg = 12'h888;
        case (color_q)
            4'd0:    fg = 12'h000;
            4'd1:    fg = 12'hFFF;
            4'd2:    fg = 12'h0F0;
            4'd3:    fg = 12'hFF0;
            4'd4:    fg = 12'hF00;
            4'd5:    fg = 12'h00F;
            4'd6:    fg = 12'h0FF;
            4'd7:    fg = 12'hF0F;
            4'd15:   fg = 12'hFFF;
            default: fg = 12'h888;
        endcase
    end

    // Output priority: blanking, then no character, then glyph bit
    always_comb begin
        rgb_d = BG_RGB;
        if (!von_q) begin
            rgb_d = 12'h000;
        end else if (!dp_q) begin
            rgb_d = BG_RGB;
        end else if (font_bit) begin
            rgb_d = blink_off ? BG_RGB : fg;
        end
    end

    // Output registers; syncs share the stage so skew to rgb is zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb       <= 12'h000;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            rgb       <= rgb_d;
            hsync_out <= hs_q;
            vsync_out <= vs_q;
        end
    end

endmodule

// File: tb/tb_text_pixel_pipe.sv
// Self-checking bench for text_pixel_pipe: directed scenarios plus random
// traffic, compared against a per-cycle history model of the pixel rules.

module tb_text_pixel_pipe;

    localparam int          D  = 2;
    localparam logic [11:0] BG = 12'h124;
    localparam int          BB = 1;
    localparam int          N  = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pixelx = '0;
    logic        video_on = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [10:0] rom_addr = '0;
    logic [1:0]  font_size = 2'd1;
    logic [3:0]  color_addr = '0;
    logic        dp = 1'b0;
    logic [10:0] font_addr;
    logic [7:0]  font_data = '0;
    logic [11:0] rgb;
    logic        hsync_out;
    logic        vsync_out;

    text_pixel_pipe #(
        .PIX_DLY  (D),
        .BG_RGB   (BG),
        .BLINK_BIT(BB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pixelx    (pixelx),
        .video_on  (video_on),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .rom_addr  (rom_addr),
        .font_size (font_size),
        .color_addr(color_addr),
        .dp        (dp),
        .font_addr (font_addr),
        .font_data (font_data),
        .rgb       (rgb),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out)
    );

    always #5 clk = ~clk;

    // Synchronous font ROM model
    logic [7:0] rom_mem [2048];
    always @(posedge clk) font_data <= rom_mem[font_addr];

    // Input history, indexed by the clock edge that samples it
    logic [9:0]  h_px   [N];
    logic        h_von  [N];
    logic        h_hs   [N];
    logic        h_vs   [N];
    logic [10:0] h_addr [N];
    logic [1:0]  h_fs   [N];
    logic [3:0]  h_col  [N];
    logic        h_dp   [N];
    int          cnt_after [N];

    int e = 0;
    int reset_edge = 0;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s edge %0d: got %h expected %h", tag, e, got, want);
        end
    endtask

    function automatic logic g_von(int i);
        return (i < reset_edge) ? 1'b0 : h_von[i];
    endfunction
    function automatic logic g_dp(int i);
        return (i < reset_edge) ? 1'b0 : h_dp[i];
    endfunction
    function automatic logic g_hs(int i);
        return (i < reset_edge) ? 1'b1 : h_hs[i];
    endfunction
    function automatic logic g_vs(int i);
        return (i < reset_edge) ? 1'b1 : h_vs[i];
    endfunction

    function automatic logic [11:0] pal(logic [3:0] c);
        case (c)
            4'd0:    return 12'h000;
            4'd1:    return 12'hFFF;
            4'd2:    return 12'h0F0;
            4'd3:    return 12'hFF0;
            4'd4:    return 12'hF00;
            4'd5:    return 12'h00F;
            4'd6:    return 12'h0FF;
            4'd7:    return 12'hF0F;
            4'd15:   return 12'hFFF;
            default: return 12'h888;
        endcase
    endfunction

    // Expected rgb after edge k: pixel-timed inputs from edge k-1-D, upstream from k-1
    function automatic logic [11:0] exp_rgb(int k);
        int          p;
        int          u;
        int          col;
        logic [7:0]  row;
        logic [11:0] fg;
        p = k - 1 - D;
        u = k - 1;
        if (!g_von(p)) return 12'h000;
        if (!g_dp(u)) return BG;
        col = (h_fs[u] == 2'd2) ? (int'(h_px[p]) % 16) / 2 : int'(h_px[p]) % 8;
        row = rom_mem[h_addr[u]];
        if (((row >> (7 - col)) & 8'd1) == 8'd0) return BG;
        fg = pal(h_col[u]);
`ifdef TEXT_PIXEL_PIPE_BLINK_EN
        begin
            int cnt;
            cnt = (u >= reset_edge) ? cnt_after[u] : 0;
            if (h_col[u] == 4'd15 && ((cnt >> BB) & 1) == 1) fg = BG;
        end
`endif
        return fg;
    endfunction

    task automatic drive(input logic [9:0] px, input logic von, input logic hs, input logic vs,
                         input logic [10:0] addr, input logic [1:0] fs, input logic [3:0] col,
                         input logic d);
        pixelx     = px;
        video_on   = von;
        hsync_in   = hs;
        vsync_in   = vs;
        rom_addr   = addr;
        font_size  = fs;
        color_addr = col;
        dp         = d;
        h_px[e+1]   = px;
        h_von[e+1]  = von;
        h_hs[e+1]   = hs;
        h_vs[e+1]   = vs;
        h_addr[e+1] = addr;
        h_fs[e+1]   = fs;
        h_col[e+1]  = col;
        h_dp[e+1]   = d;
    endtask

    task automatic tick();
        logic prev;
        int   cp;
        @(posedge clk);
        e++;
        cp   = (e - 1 >= reset_edge) ? cnt_after[e-1] : 0;
        prev = (e - 1 >= reset_edge) ? h_vs[e-1] : 1'b1;
        cnt_after[e] = (cp + ((prev && !h_vs[e]) ? 1 : 0)) % 256;
        #1;
        check_eq("rgb", rgb, exp_rgb(e));
        check_eq("hsync_out", {11'd0, hsync_out}, {11'd0, g_hs(e - 1 - D)});
        check_eq("vsync_out", {11'd0, vsync_out}, {11'd0, g_vs(e - 1 - D)});
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
        rom_mem[11'h100] = 8'h81;
        rom_mem[11'h101] = 8'hFF;

        // Reset held 5 cycles with video_on=1, dp=0
        video_on = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            e++;
            #1;
            check_eq("rst_rgb", rgb, 12'h000);
            check_eq("rst_hs", {11'd0, hsync_out}, 12'd1);
            check_eq("rst_vs", {11'd0, vsync_out}, 12'd1);
        end
        reset = 1'b0;
        reset_edge = e + 1;
        for (int i = 0; i < 10; i++) begin
            drive(10'(i), 1'b1, 1'b1, 1'b1, 11'h000, 2'd1, 4'd0, 1'b0);
            tick();
        end

        // Row 1000_0001 in colour 2, native then 2x width
        for (int i = 0; i < 16 + D + 2; i++) begin
            drive(10'(288 + i), 1'b1, 1'b1, 1'b1, 11'h100, 2'd1, 4'd2, 1'b1);
            tick();
        end
        for (int i = 0; i < 16 + D + 2; i++) begin
            drive(10'(288 + i), 1'b1, 1'b1, 1'b1, 11'h100, 2'd2, 4'd2, 1'b1);
            tick();
        end

        // Blanked solid bar, then visible
        for (int i = 0; i < 16; i++) begin
            drive(10'(300 + i), (i >= 8), 1'b1, 1'b1, 11'h101, 2'd1, 4'd4, 1'b1);
            tick();
        end

        // 96-cycle hsync pulse, then 96-cycle vsync pulse
        for (int i = 0; i < 106; i++) begin
            drive(10'(i), 1'b1, (i >= 96), 1'b1, 11'h101, 2'd1, 4'd3, 1'b1);
            tick();
        end
        for (int i = 0; i < 106; i++) begin
            drive(10'(i), 1'b1, 1'b1, (i >= 96), 11'h101, 2'd1, 4'd5, 1'b1);
            tick();
        end

        // Mid-line reset while hsync is low and text is lit
        for (int i = 0; i < 6; i++) begin
            drive(10'(i), 1'b1, 1'b0, 1'b0, 11'h101, 2'd1, 4'd4, 1'b1);
            tick();
        end
        #1 reset = 1'b1;
        #1;
        check_eq("midrst_rgb", rgb, 12'h000);
        check_eq("midrst_hs", {11'd0, hsync_out}, 12'd1);
        check_eq("midrst_vs", {11'd0, vsync_out}, 12'd1);
        @(posedge clk);
        e++;
        @(posedge clk);
        e++;
        #1 reset = 1'b0;
        reset_edge = e + 1;

        // Several short frames with colour 15, then colour 1
        for (int c = 0; c < 2; c++) begin
            for (int f = 0; f < 6; f++) begin
                for (int i = 0; i < 15; i++) begin
                    drive(10'(i), 1'b1, 1'b1, (i >= 3), 11'h101, 2'd1,
                          (c == 0) ? 4'd15 : 4'd1, 1'b1);
                    tick();
                end
            end
        end

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            drive(10'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) != 0),
                  ($urandom_range(0, 31) != 0),
                  ($urandom_range(0, 3) == 0) ? 11'h101 : 11'($urandom),
                  2'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/text_pixel_pipe.md
Name: text_pixel_pipe

Overview:
- Downstream of the character-placement stage, which emits a font ROM address, colour index, font size and a "data present" flag per pixel.
- Drives the external synchronous font ROM and selects the pixel bit for the current column.
- Maps colour index to 12-bit RGB, blanks outside the visible area, and re-aligns hsync/vsync with the RGB output.
- Output feeds the VGA pins directly.

Parameters:
- PIX_DLY, 1: cycles between pixelx/sync/video_on arriving here and the matching upstream outputs (rom_addr, color_addr, font_size, dp); 1..4.
- BG_RGB, 12'h000: background colour, used when dp=0 or the font bit is 0.
- BLINK_BIT, 5: frame-counter bit that gates blinking (BLINK_EN only).

Ports:
- clk, in, 1: pixel clock.
- reset, in, 1: asynchronous, active-high.
- pixelx, in, 10: current pixel x, same timing as the upstream stage's input.
- video_on, in, 1: visible-area flag, same timing as pixelx.
- hsync_in, in, 1: active-low horizontal sync, same timing as pixelx.
- vsync_in, in, 1: active-low vertical sync, same timing as pixelx.
- rom_addr, in, 11: upstream font address {char[6:0], row[3:0]}.
- font_size, in, 2: 1 = native 8-px columns, 2 = 2x horizontal; 0 and 3 behave as 1.
- color_addr, in, 4: colour index.
- dp, in, 1: character present.
- font_addr, out, 11: ROM address; combinational copy of rom_addr.
- font_data, in, 8: ROM row data, valid exactly 1 cycle after font_addr; bit 7 is the leftmost column.
- rgb, out, 12: {R[3:0], G[3:0], B[3:0]}, registered.
- hsync_out, out, 1: hsync delayed to align with rgb.
- vsync_out, out, 1: vsync delayed to align with rgb.

Behaviour:
- Reset is asynchronous, active-high. All pipeline registers clear to 0; rgb = 0; hsync_out = vsync_out = 1 (inactive); frame counter = 0.
- Alignment delay line: pixelx[3:0], video_on, hsync_in and vsync_in are each delayed PIX_DLY cycles. Call this time T0, which coincides with the upstream outputs.
- Stage 1 (T0 -> T0+1):
  - font_addr = rom_addr, so the ROM returns the row at T0+1.
  - Registered at T0+1: color_addr, dp, video_on, hsync, vsync, and col.
  - col = pixelx[3:1] if font_size == 2, otherwise pixelx[2:0].
- Stage 2 (T0+1 -> T0+2):
  - bit = font_data[7 - col].
  - fg = palette[color_addr].
  - Registered output rgb, first matching rule wins:
    - video_on == 0: 12'h000.
    - dp == 0: BG_RGB.
    - bit == 1: fg.
    - otherwise: BG_RGB.
  - hsync_out and vsync_out come from the same stage, so sync-to-rgb skew is 0.
- Total latency is PIX_DLY + 2 cycles from pixelx to rgb.
- Palette (fixed; no other indices exist because the index is 4 bits):
  - 0 = 000
  - 1 = FFF
  - 2 = 0F0
  - 3 = FF0
  - 4 = F00
  - 5 = 00F
  - 6 = 0FF
  - 7 = F0F
  - 8..14 = 888
  - 15 = FFF
- The pipeline has no stall or handshake. It advances every clk.
- Back-to-back characters with different font_size are handled per pixel, with no bubble.
- Reset mid-line: outputs go to reset values immediately. The first valid rgb appears PIX_DLY + 2 cycles after reset deassertion; earlier rgb stays 0 because the delayed video_on is 0 after reset.
- A solid-bar glyph (ROM row 8'hFF) gives fg on all 8 columns.

Optional Feature:
- Macro: TEXT_PIXEL_PIPE_BLINK_EN.
- When defined:
  - An 8-bit frame counter increments on each 1->0 edge of vsync_in. Edge detection uses a registered previous value.
  - The counter wraps 255 -> 0.
  - When color_addr == 15 and frame_cnt[BLINK_BIT] == 1, fg is replaced by BG_RGB.
  - All other indices are unaffected.
- When undefined: no counter logic exists, and index 15 always shows FFF.

Test Plan:
- Reset held 5 cycles, then released with video_on = 1, dp = 0 -> rgb = 000 for PIX_DLY + 2 cycles, then BG_RGB (000); hsync_out = vsync_out = 1 during reset.
- dp = 1, color_addr = 2, font_size = 1, ROM row 8'b1000_0001, pixelx = 288..295 -> rgb = 0F0 at columns 0 and 7, 000 at columns 1..6, each PIX_DLY + 2 cycles after its pixelx.
- Same row with font_size = 2, pixelx = 288..303 -> rgb = 0F0 for the first two pixels and the last two pixels, 000 otherwise.
- video_on = 0 with dp = 1, color_addr = 4, row 8'hFF -> rgb = 000. Then video_on = 1 -> rgb = F00 after PIX_DLY + 2 cycles.
- hsync_in pulse low for 96 cycles -> hsync_out low for exactly 96 cycles, delayed PIX_DLY + 2 cycles; identical timing on vsync.
- TEXT_PIXEL_PIPE_BLINK_EN defined, BLINK_BIT = 1, color_addr = 15, row 8'hFF:
  - frames 0..1 -> rgb = FFF.
  - frames 2..3 -> rgb = BG_RGB.
  - color_addr = 1 -> rgb = FFF in all frames.
